// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: measures NUM_BITS oscillator pairs and packs the comparisons into a response word.
// Latency: start to done = NUM_BITS*(1+WINDOW+SETTLE+1)+1 cycles; outputs decode directly from the state register.
// Backpressure: none; start is a one-cycle request that is accepted only in IDLE and dropped at any other time.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   start, challenge      run request; challenge[3:0]/[7:4] are the base RO indices, latched on an accepted start
//   cnt1, cnt2            oscillator counter values for the currently selected pair
//   select1, select2      pair mux selects (base + bit index, 4-bit wrap)
//   ro_enable, ro_reset   oscillator/counter enable and counter clear
//   busy, done            run in progress, one-cycle completion pulse
//   response, unstable    response bits and per-bit low-margin flags, held until the next accepted start
// Build option: define RO_PUF_MARGIN_EN to flag bits whose count difference is below MARGIN.
module ro_puf_sequencer #(
  parameter int NUM_BITS = 8,
  parameter int WINDOW   = 4095,
  parameter int SETTLE   = 4
`ifdef RO_PUF_MARGIN_EN
  , parameter int MARGIN = 16
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          challenge,
  input  logic [11:0]         cnt1,
  input  logic [11:0]         cnt2,
  output logic [3:0]          select1,
  output logic [3:0]          select2,
  output logic                ro_enable,
  output logic                ro_reset,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] response,
  output logic [NUM_BITS-1:0] unstable
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_t;

  localparam logic [11:0] WIN_LAST = 12'(WINDOW - 1);
  localparam logic [11:0] SET_LAST = 12'(SETTLE - 1);
  localparam logic [3:0]  LAST_BIT = 4'(NUM_BITS - 1);

  state_t                state_q;
  state_t                state_d;
  logic [11:0]           win_cnt_q;
  logic [3:0]            bit_q;
  logic [3:0]            base1_q;
  logic [3:0]            base2_q;
  logic [NUM_BITS-1:0]   response_q;
  logic [NUM_BITS-1:0]   unstable_q;
  logic                  pair_same;
  logic                  resp_bit;
  logic                  unst_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_RUN;
      ST_RUN:     if (win_cnt_q == WIN_LAST) state_d = ST_SETTLE;
      ST_SETTLE:  if (win_cnt_q == SET_LAST) state_d = ST_COMPARE;
      ST_COMPARE: state_d = (bit_q == LAST_BIT) ? ST_DONE : ST_CLEAR;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Selects are derived from the latched bases, so they cannot move while a bit is being measured.
  assign select1   = base1_q + bit_q;
  assign select2   = base2_q + bit_q;
  assign pair_same = (select1 == select2);
  assign resp_bit  = !pair_same && (cnt1 > cnt2);

`ifdef RO_PUF_MARGIN_EN
  logic [12:0] diff;
  logic [12:0] abs_diff;
  // Zero-extended 13-bit subtract keeps the sign of cnt1-cnt2 for the full 12-bit range.
  assign diff     = {1'b0, cnt1} - {1'b0, cnt2};
  assign abs_diff = diff[12] ? (~diff + 13'd1) : diff;
  assign unst_bit = pair_same || (abs_diff < 13'(MARGIN));
`else
  assign unst_bit = pair_same;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_cnt_q  <= '0;
      bit_q      <= '0;
      base1_q    <= '0;
      base2_q    <= '0;
      response_q <= '0;
      unstable_q <= '0;
    end else begin
      // Restart the shared window/settle counter on every state change.
      win_cnt_q <= (state_d != state_q) ? 12'd0 : win_cnt_q + 12'd1;
      if (state_q == ST_IDLE && start) begin
        base1_q    <= challenge[3:0];
        base2_q    <= challenge[7:4];
        bit_q      <= '0;
        response_q <= '0;
        unstable_q <= '0;
      end
      if (state_q == ST_COMPARE) begin
        for (int b = 0; b < NUM_BITS; b++) begin
          if (b == int'(bit_q)) begin
            response_q[b] <= resp_bit;
            unstable_q[b] <= unst_bit;
          end
        end
        if (bit_q != LAST_BIT) bit_q <= bit_q + 4'd1;
      end
    end
  end

  assign ro_enable = (state_q == ST_RUN);
  // Counters stay cleared for as long as reset is held, not just after the first edge.
  assign ro_reset  = reset || (state_q == ST_CLEAR);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign response  = response_q;
  assign unstable  = unstable_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Bench for ro_puf_sequencer: behavioural timeline/response model, per-cycle compare, directed and random runs.
// Latency: checks done arrives LAT cycles after the accepted start.
// Backpressure: injects start while busy and in the done cycle and expects it to be ignored.
module tb_ro_puf_sequencer;

  localparam int NB  = 4;
  localparam int WIN = 10;
  localparam int SET = 2;
  localparam int PER = 1 + WIN + SET + 1;
  localparam int LAT = NB * PER + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    challenge;
  logic [11:0]   cnt1, cnt2;
  logic [3:0]    select1, select2;
  logic          ro_enable, ro_reset, busy, done;
  logic [NB-1:0] response, unstable;

  logic [11:0]   f1 [16];
  logic [11:0]   f2 [16];

  int n_tests = 0;
  int n_fail  = 0;

  ro_puf_sequencer #(.NUM_BITS(NB), .WINDOW(WIN), .SETTLE(SET)) dut (
    .clock(clock), .reset(reset), .start(start), .challenge(challenge),
    .cnt1(cnt1), .cnt2(cnt2), .select1(select1), .select2(select2),
    .ro_enable(ro_enable), .ro_reset(ro_reset), .busy(busy), .done(done),
    .response(response), .unstable(unstable)
  );

  always #5 clock = ~clock;

  // Oscillator bank model: each select picks a fixed count from its bank.
  assign cnt1 = f1[select1];
  assign cnt2 = f2[select2];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: k = cycles since the accepted start (-1 when idle); expected result computed at acceptance.
  int            k = -1;
  logic [7:0]    m_c = '0;
  logic [NB-1:0] exp_resp = '0;
  logic [NB-1:0] exp_unst = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      k = -1;
      exp_resp = '0;
      exp_unst = '0;
    end else if (k < 0) begin
      if (start) begin
        k = 1;
        m_c = challenge;
        for (int i = 0; i < NB; i++) begin
          int s1, s2, d;
          s1 = (int'(challenge[3:0]) + i) % 16;
          s2 = (int'(challenge[7:4]) + i) % 16;
          d  = int'(f1[s1]) - int'(f2[s2]);
          exp_resp[i] = (s1 != s2) && (d > 0);
          exp_unst[i] = (s1 == s2);
`ifdef RO_PUF_MARGIN_EN
          if (d < 16 && d > -16) exp_unst[i] = 1'b1;
`endif
        end
      end
    end else if (k == LAT) begin
      k = -1;
    end else begin
      k++;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("rst_ro_reset", ro_reset, 1);
      check("rst_ro_enable", ro_enable, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_selects", {select2, select1}, 0);
      check("rst_response", response, 0);
      check("rst_unstable", unstable, 0);
    end else if (k < 0) begin
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_ro_enable", ro_enable, 0);
      check("idle_ro_reset", ro_reset, 0);
      check("idle_response", response, exp_resp);
      check("idle_unstable", unstable, exp_unst);
    end else if (k == LAT) begin
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_ro_enable", ro_enable, 0);
      check("done_response", response, exp_resp);
      check("done_unstable", unstable, exp_unst);
    end else begin
      int b, p;
      logic [3:0] e1, e2;
      b  = (k - 1) / PER;
      p  = (k - 1) % PER;
      e1 = m_c[3:0] + 4'(b);
      e2 = m_c[7:4] + 4'(b);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_ro_reset", ro_reset, (p == 0) ? 1 : 0);
      check("run_ro_enable", ro_enable, (p >= 1 && p <= WIN) ? 1 : 0);
      check("run_select1", select1, e1);
      check("run_select2", select2, e2);
    end
  end

  task automatic run(input logic [7:0] c, input int poke_at, input bit poke_done,
                     output int lat, output int ens, output logic [7:0] sel_a, output logic [7:0] sel_b);
    @(negedge clock);
    #1;
    challenge = c;
    start = 1'b1;
    lat = -1;
    ens = 0;
    sel_a = '0;
    sel_b = '0;
    for (int cyc = 1; cyc <= LAT + 20; cyc++) begin
      @(negedge clock);
      if (ro_enable) ens++;
      if (cyc == 1) sel_a = {select2, select1};
      if (cyc == PER + 1) sel_b = {select2, select1};
      if (done) begin
        lat = cyc;
        if (poke_done) begin
          #1 start = 1'b1;
          @(negedge clock);
        end
        #1 start = 1'b0;
        break;
      end
      #1 start = (cyc == poke_at);
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, ens, dn;
    logic [7:0] sa, sb;
    reset = 1'b1;
    start = 1'b0;
    challenge = '0;
    for (int j = 0; j < 16; j++) begin
      f1[j] = '0;
      f2[j] = '0;
    end
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;

    // Pairs 0 and 2 win for challenge 0x10.
    f1[0] = 12'd200; f1[1] = 12'd50; f1[2] = 12'd200; f1[3] = 12'd50;
    for (int j = 1; j <= 4; j++) f2[j] = 12'd100;
    run(8'h10, 0, 0, lat, ens, sa, sb);
    check("lat_0x10", lat, 57);
    check("resp_0x10", response, 4'b0101);
    check("unst_0x10", unstable, 4'b0000);
    check("en_cycles_0x10", ens, NB * WIN);
    check("sel_bit0_0x10", sa, 8'h10);
    check("sel_bit1_0x10", sb, 8'h21);

    run(8'hF0, 0, 0, lat, ens, sa, sb);
    check("sel_bit0_wrap", sa, 8'hF0);
    check("sel_bit1_wrap", sb, 8'h01);
    check("en_cycles_wrap", ens, NB * WIN);

    run(8'h33, 0, 0, lat, ens, sa, sb);
    check("resp_0x33", response, 4'b0000);
    check("unst_0x33", unstable, 4'b1111);

    // Start while busy and in the done cycle: exactly one done, result unchanged.
    run(8'h10, 20, 1, lat, ens, sa, sb);
    check("lat_poked", lat, LAT);
    dn = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      if (done) dn++;
    end
    check("no_restart_done", dn, 0);
    check("no_restart_busy", busy, 0);
    check("resp_poked", response, 4'b0101);

    // Reset in the middle of RUN.
    @(negedge clock);
    #1 challenge = 8'h10; start = 1'b1;
    @(negedge clock);
    #1 start = 1'b0;
    repeat (5) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_ro_enable", ro_enable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    dn = 0;
    for (int j = 0; j < LAT + 10; j++) begin
      @(negedge clock);
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);
    run(8'h10, 0, 0, lat, ens, sa, sb);
    check("lat_after_rst", lat, 57);
    check("resp_after_rst", response, 4'b0101);

    // Random runs: random banks, challenges, equal counts, near-margin deltas, stray starts.
    for (int r = 0; r < 14; r++) begin
      int mode, off, v;
      logic [7:0] c;
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) c[7:4] = c[3:0];
      mode = int'($urandom_range(0, 2));
      off = int'(c[3:0]) - int'(c[7:4]);
      for (int j = 0; j < 16; j++) f1[j] = 12'($urandom_range(0, 4095));
      for (int j = 0; j < 16; j++) begin
        if (mode == 0) begin
          f2[j] = 12'($urandom_range(0, 4095));
        end else begin
          v = int'(f1[(j + off) & 15]);
          if (mode == 2) v = v + int'($urandom_range(0, 40)) - 20;
          if (v < 0) v = 0;
          if (v > 4095) v = 4095;
          f2[j] = 12'(v);
        end
      end
      run(c, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, LAT - 2)) : 0,
          1'($urandom_range(0, 1)), lat, ens, sa, sb);
      check("rand_latency", lat, LAT);
      check("rand_en_cycles", ens, NB * WIN);
      check("rand_response", response, exp_resp);
      check("rand_unstable", unstable, exp_unst);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
